// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : First-word fall-through FIFO between fetch and decode, holding
//               {PC, instruction, BP decision, BP enable} per entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_F,
    input  logic [31:0]                PC_in_F,
    input  logic [31:0]                instr_in_F,
    input  logic                       BP_decision_in_F,
    input  logic                       BP_en_in_F,
    input  logic                       stall_DE,
    input  logic                       flush_DE,
    output logic                       ready_F,
    output logic                       valid_F,
    output logic [31:0]                normal_F,
    output logic [31:0]                PC_out_F,
    output logic [31:0]                InstructionMemory_out_F,
    output logic                       BP_decision_F,
    output logic                       BP_en_F,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [31:0]     c_NOP  = 32'h0000_0013;
    localparam logic [AW:0]     c_FULL = (AW+1)'(DEPTH);

    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_instr_mem [DEPTH];
    logic        r_bpd_mem   [DEPTH];
    logic        r_bpe_mem   [DEPTH];

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign valid_F = (r_count != '0);
    assign ready_F = (r_count != c_FULL);
    assign count   = r_count;

    // Flush overrides both directions so a redirect never leaks a stale entry.
    assign w_pop  = valid_F && !stall_DE && !flush_DE;
    assign w_push = push_F  && ready_F   && !flush_DE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_DE) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= PC_in_F;
            r_instr_mem[r_wr_ptr] <= instr_in_F;
            r_bpd_mem[r_wr_ptr]   <= BP_decision_in_F;
            r_bpe_mem[r_wr_ptr]   <= BP_en_in_F;
        end
    end

    assign PC_out_F                = valid_F ? r_pc_mem[r_rd_ptr]            : 32'h0;
    assign normal_F                = valid_F ? r_pc_mem[r_rd_ptr] + 32'd4    : 32'h0;
    assign InstructionMemory_out_F = valid_F ? r_instr_mem[r_rd_ptr]         : c_NOP;
    assign BP_decision_F           = valid_F ? r_bpd_mem[r_rd_ptr]           : 1'b0;
    assign BP_en_F                 = valid_F ? r_bpe_mem[r_rd_ptr]           : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_F;
    logic [31:0] PC_in_F;
    logic [31:0] instr_in_F;
    logic        BP_decision_in_F;
    logic        BP_en_in_F;
    logic        stall_DE;
    logic        flush_DE;
    logic        ready_F;
    logic        valid_F;
    logic [31:0] normal_F;
    logic [31:0] PC_out_F;
    logic [31:0] InstructionMemory_out_F;
    logic        BP_decision_F;
    logic        BP_en_F;
    logic [$clog2(DEPTH):0] count;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .push_F                  (push_F),
        .PC_in_F                 (PC_in_F),
        .instr_in_F              (instr_in_F),
        .BP_decision_in_F        (BP_decision_in_F),
        .BP_en_in_F              (BP_en_in_F),
        .stall_DE                (stall_DE),
        .flush_DE                (flush_DE),
        .ready_F                 (ready_F),
        .valid_F                 (valid_F),
        .normal_F                (normal_F),
        .PC_out_F                (PC_out_F),
        .InstructionMemory_out_F (InstructionMemory_out_F),
        .BP_decision_F           (BP_decision_F),
        .BP_en_F                 (BP_en_F),
        .count                   (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered queue of whole entries.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        bd;
        logic        be;
    } ent_t;

    ent_t q[$];
    ent_t e_new;
    bit   m_pop;
    bit   m_push;

    always @(posedge clk or posedge rst) begin
        if (rst || flush_DE) begin
            q.delete();
        end else begin
            m_pop  = (q.size() != 0) && !stall_DE;
            m_push = push_F && (q.size() < DEPTH);
            e_new  = '{pc: PC_in_F, ins: instr_in_F, bd: BP_decision_in_F, be: BP_en_in_F};
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(e_new);
        end
    end

    // Compare process: outputs depend only on stored state, so check mid-cycle.
    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_ready", 32'(ready_F), 32'(q.size() < DEPTH));
        chk("m_valid", 32'(valid_F), 32'(q.size() != 0));
        if (q.size() == 0) begin
            chk("m_pc_empty",    PC_out_F, 32'h0);
            chk("m_nrm_empty",   normal_F, 32'h0);
            chk("m_ins_empty",   InstructionMemory_out_F, 32'h13);
            chk("m_bp_empty",    {30'h0, BP_decision_F, BP_en_F}, 32'h0);
        end else begin
            chk("m_pc",  PC_out_F, q[0].pc);
            chk("m_nrm", normal_F, q[0].pc + 32'd4);
            chk("m_ins", InstructionMemory_out_F, q[0].ins);
            chk("m_bp",  {30'h0, BP_decision_F, BP_en_F}, {30'h0, q[0].bd, q[0].be});
        end
    end

    task automatic drive(input logic p, input logic [31:0] pc, input logic [31:0] ins,
                         input logic bd, input logic be, input logic st, input logic fl);
        push_F = p; PC_in_F = pc; instr_in_F = ins;
        BP_decision_in_F = bd; BP_en_in_F = be; stall_DE = st; flush_DE = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        chk("rst_valid", 32'(valid_F), 32'h0);
        chk("rst_ready", 32'(ready_F), 32'h1);
        chk("rst_ins",   InstructionMemory_out_F, 32'h13);
        chk("rst_count", 32'(count), 32'h0);
        rst = 1'b0;

        // Single push shows up next cycle, then drains to a bubble
        drive(1, 32'h100, 32'h0050_0093, 0, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("one_valid", 32'(valid_F), 32'h1);
        chk("one_pc",    PC_out_F, 32'h100);
        chk("one_nrm",   normal_F, 32'h104);
        chk("one_bpen",  32'(BP_en_F), 32'h1);
        chk("one_ins",   InstructionMemory_out_F, 32'h0050_0093);
        cyc();
        chk("one_drain_count", 32'(count), 32'h0);
        chk("one_drain_ins",   InstructionMemory_out_F, 32'h13);

        // Fill under stall, overflow push ignored, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(i * 4), 32'hA5A5_0000 | 32'(i), 0, 0, 1, 0);
            cyc();
            chk("fill_count", 32'(count), 32'((i < 4) ? i + 1 : 4));
        end
        chk("fill_ready", 32'(ready_F), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",  PC_out_F, 32'(i * 4));
            chk("drain_ins", InstructionMemory_out_F, 32'hA5A5_0000 | 32'(i));
            cyc();
        end
        chk("drain_empty", 32'(valid_F), 32'h0);

        // Steady push+pop at count=2 across pointer wrap
        drive(1, 32'h300, 32'h1, 0, 0, 1, 0); cyc();
        drive(1, 32'h304, 32'h2, 0, 0, 1, 0); cyc();
        for (int k = 0; k < 6; k++) begin
            chk("pp_head", PC_out_F, 32'h300 + 32'(4 * k));
            drive(1, 32'h308 + 32'(4 * k), 32'(k + 3), 1, 1, 0, 0);
            cyc();
            chk("pp_count", 32'(count), 32'h2);
        end
        drive(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // Flush with simultaneous push
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h400 + 32'(4 * i), 32'h77, 1, 1, 1, 0); cyc();
        end
        drive(1, 32'h500, 32'h88, 1, 1, 1, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(valid_F), 32'h0);
        chk("flush_ins",   InstructionMemory_out_F, 32'h13);
        cyc();
        chk("flush_still_empty", 32'(count), 32'h0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 32'h99, 0, 0, 1, 0); cyc();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("pre_arst_count", 32'(count), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_F), 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        cyc();
        rst = 1'b0;
        drive(1, 32'h200, 32'h0000_0013, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("arst_first_pc", PC_out_F, 32'h200);
        cyc();

        // PC+4 wraps at 32 bits
        drive(1, 32'hFFFF_FFFC, 32'h1234_5678, 1, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc",  PC_out_F, 32'hFFFF_FFFC);
        chk("wrap_nrm", normal_F, 32'h0);
        cyc();

        // Randomized traffic against the queue model
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) < 65), $urandom, $urandom,
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 35), ($urandom_range(0, 49) == 0));
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc(); cyc(); cyc();
        chk("end_empty", 32'(count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
